// File: rtl/bus_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// bus_scheduler_pkg : shared types and constants for the Sysbus scheduler
// Rev 1.0
// ============================================================================
package bus_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_WDATA = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWNER_IBUS = 1'b0,
      OWNER_DBUS = 1'b1
   } owner_e;

   localparam int SYSBUS_WRITE_BIT = 12;
   localparam int BEATS_PER_XFER   = 8;
   localparam int BEAT_CNT_W       = $clog2(BEATS_PER_XFER);

   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_XFER - 1);

endpackage
`default_nettype wire

// File: rtl/bus_scheduler_if.sv
`default_nettype none
// ============================================================================
// bus_scheduler_if : requester-side and Sysbus-side signals of the scheduler
// Rev 1.0
// ============================================================================
interface bus_scheduler_if #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
);
   logic                      ibus_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] ibus_req;
   logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag;
   logic                      ibus_reqack;
   logic                      ibus_respack;
   logic                      ibus_respcyc;
   logic [BUS_DATA_WIDTH-1:0] ibus_resp;
   logic [BUS_TAG_WIDTH-1:0]  ibus_resptag;

   logic                      dbus_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] dbus_req;
   logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag;
   logic                      dbus_reqack;
   logic                      dbus_respack;
   logic                      dbus_respcyc;
   logic [BUS_DATA_WIDTH-1:0] dbus_resp;
   logic [BUS_TAG_WIDTH-1:0]  dbus_resptag;

   logic                      bus_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] bus_req;
   logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
   logic                      bus_reqack;
   logic                      bus_respcyc;
   logic [BUS_DATA_WIDTH-1:0] bus_resp;
   logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
   logic                      bus_respack;

   modport slave (
      input  ibus_reqcyc, ibus_req, ibus_reqtag, ibus_respack,
      output ibus_reqack, ibus_respcyc, ibus_resp, ibus_resptag,
      input  dbus_reqcyc, dbus_req, dbus_reqtag, dbus_respack,
      output dbus_reqack, dbus_respcyc, dbus_resp, dbus_resptag,
      output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
   );

   modport master (
      output ibus_reqcyc, ibus_req, ibus_reqtag, ibus_respack,
      input  ibus_reqack, ibus_respcyc, ibus_resp, ibus_resptag,
      output dbus_reqcyc, dbus_req, dbus_reqtag, dbus_respack,
      input  dbus_reqack, dbus_respcyc, dbus_resp, dbus_resptag,
      input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag
   );
endinterface
`default_nettype wire

// File: rtl/bus_scheduler_rr_picker.sv
`default_nettype none
// ============================================================================
// bus_rr_picker : 2-way round-robin choice between ibus and dbus
// Rev 1.0
// ============================================================================
module bus_rr_picker
   import bus_scheduler_pkg::*;
(
   input  wire logic   req_ibus,
   input  wire logic   req_dbus,
   input  wire owner_e last_grant,
   output owner_e      grant,
   output logic        grant_valid
);

   always_comb begin
      grant_valid = req_ibus | req_dbus;
      grant       = OWNER_IBUS;
      // On contention the side that did not win last time goes first
      if (req_ibus && req_dbus) begin
         grant = (last_grant == OWNER_IBUS) ? OWNER_DBUS : OWNER_IBUS;
      end else if (req_dbus) begin
         grant = OWNER_DBUS;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_scheduler.sv
`default_nettype none
// ============================================================================
// bus_scheduler : arbitrates ibus/dbus onto one Sysbus, sequencing 8-beat bursts
// Rev 1.0
// ============================================================================
module bus_scheduler
   import bus_scheduler_pkg::*;
(
   input  wire logic      clk,
   input  wire logic      reset,
   bus_scheduler_if.slave bus
);

   state_e                  state_q, state_d;
   owner_e                  owner_q, owner_d;
   owner_e                  last_q, last_d;
   logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;

   owner_e                  w_grant;
   logic                    w_grant_vld;
   logic                    w_own_dbus;
   logic                    w_req_phase;
   logic                    w_resp_phase;
   logic                    w_own_reqcyc;
   logic                    w_own_respack;
   logic                    w_req_beat;
   logic                    w_resp_beat;
   logic                    w_is_write;

   bus_rr_picker u_picker (
      .req_ibus    (bus.ibus_reqcyc),
      .req_dbus    (bus.dbus_reqcyc),
      .last_grant  (last_q),
      .grant       (w_grant),
      .grant_valid (w_grant_vld)
   );

   assign w_own_dbus    = (owner_q == OWNER_DBUS);
   assign w_req_phase   = (state_q == ST_ADDR) || (state_q == ST_WDATA);
   assign w_resp_phase  = (state_q == ST_RESP);
   assign w_own_reqcyc  = w_own_dbus ? bus.dbus_reqcyc  : bus.ibus_reqcyc;
   assign w_own_respack = w_own_dbus ? bus.dbus_respack : bus.ibus_respack;
   assign w_is_write    = w_own_dbus ? bus.dbus_reqtag[SYSBUS_WRITE_BIT]
                                     : bus.ibus_reqtag[SYSBUS_WRITE_BIT];
   assign w_req_beat    = w_req_phase  & w_own_reqcyc & bus.bus_reqack;
   assign w_resp_beat   = w_resp_phase & bus.bus_respcyc & w_own_respack;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (w_grant_vld) begin
               state_d = ST_ADDR;
               owner_d = w_grant;
               last_d  = w_grant;
               cnt_d   = '0;
            end
         end
         ST_ADDR: begin
            if (w_req_beat) begin
               state_d = w_is_write ? ST_WDATA : ST_RESP;
               cnt_d   = '0;
            end else if (!w_own_reqcyc) begin
               state_d = ST_IDLE;
            end
         end
         ST_WDATA: begin
            if (w_req_beat) begin
               cnt_d = cnt_q + BEAT_CNT_W'(1);
               if (cnt_q == LAST_BEAT) state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (w_resp_beat) begin
               cnt_d = cnt_q + BEAT_CNT_W'(1);
               if (cnt_q == LAST_BEAT) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         owner_q <= OWNER_IBUS;
         last_q  <= OWNER_IBUS;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Every output is gated by the registered phase, so reset zeroes them at once
   assign bus.bus_reqcyc   = w_req_phase & w_own_reqcyc;
   assign bus.bus_req      = w_req_phase ? (w_own_dbus ? bus.dbus_req : bus.ibus_req) : '0;
   assign bus.bus_reqtag   = w_req_phase ? (w_own_dbus ? bus.dbus_reqtag : bus.ibus_reqtag) : '0;
   assign bus.ibus_reqack  = w_req_phase & ~w_own_dbus & bus.bus_reqack;
   assign bus.dbus_reqack  = w_req_phase &  w_own_dbus & bus.bus_reqack;

   assign bus.bus_respack  = w_resp_phase & w_own_respack;
   assign bus.ibus_respcyc = w_resp_phase & ~w_own_dbus & bus.bus_respcyc;
   assign bus.dbus_respcyc = w_resp_phase &  w_own_dbus & bus.bus_respcyc;
   assign bus.ibus_resp    = w_resp_phase ? bus.bus_resp    : '0;
   assign bus.dbus_resp    = w_resp_phase ? bus.bus_resp    : '0;
   assign bus.ibus_resptag = w_resp_phase ? bus.bus_resptag : '0;
   assign bus.dbus_resptag = w_resp_phase ? bus.bus_resptag : '0;

endmodule
`default_nettype wire

// File: tb/tb_bus_scheduler.sv
`default_nettype none
// ============================================================================
// tb_bus_scheduler : directed scenarios plus random traffic against a
// transaction-level model of the scheduler
// Rev 1.0
// ============================================================================
module tb_bus_scheduler;

   localparam int DW = 64;
   localparam int TW = 13;
   localparam int WAIT_ADDR = 0;
   localparam int WRITING   = 1;
   localparam int READING   = 2;

   logic clk;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   bus_scheduler_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif ();

   bus_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level model: who holds the bus, what it is doing, beats done
   bit m_active;
   int m_who;
   int m_stage;
   int m_beats;
   int m_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit orc;
      bit write;
      if (!m_active) begin
         if (bif.ibus_reqcyc || bif.dbus_reqcyc) begin
            if (bif.ibus_reqcyc && bif.dbus_reqcyc) m_who = 1 - m_last;
            else                                    m_who = bif.dbus_reqcyc ? 1 : 0;
            m_last   = m_who;
            m_active = 1'b1;
            m_stage  = WAIT_ADDR;
            m_beats  = 0;
         end
      end else begin
         orc   = (m_who == 1) ? bif.dbus_reqcyc : bif.ibus_reqcyc;
         write = (m_who == 1) ? bif.dbus_reqtag[12] : bif.ibus_reqtag[12];
         if (m_stage == WAIT_ADDR) begin
            if (orc && bif.bus_reqack) begin
               m_stage = write ? WRITING : READING;
               m_beats = 0;
            end else if (!orc) begin
               m_active = 1'b0;
            end
         end else if (m_stage == WRITING) begin
            if (orc && bif.bus_reqack) m_beats++;
            if (m_beats == 8) m_active = 1'b0;
         end else begin
            if (bif.bus_respcyc && ((m_who == 1) ? bif.dbus_respack : bif.ibus_respack)) m_beats++;
            if (m_beats == 8) m_active = 1'b0;
         end
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active = 1'b0;
         m_who    = 0;
         m_stage  = WAIT_ADDR;
         m_beats  = 0;
         m_last   = 0;
      end else begin
         model_step();
      end
   end

   // Single compare point, half a cycle away from the active edge
   always @(negedge clk) begin : cmp
      bit reqph, respph, dsel, orc, oresp;
      reqph  = m_active && (m_stage != READING);
      respph = m_active && (m_stage == READING);
      dsel   = (m_who == 1);
      orc    = dsel ? bif.dbus_reqcyc  : bif.ibus_reqcyc;
      oresp  = dsel ? bif.dbus_respack : bif.ibus_respack;
      chk("bus_reqcyc",   64'(bif.bus_reqcyc),   64'(reqph && orc));
      chk("ibus_reqack",  64'(bif.ibus_reqack),  64'(reqph && !dsel && bif.bus_reqack));
      chk("dbus_reqack",  64'(bif.dbus_reqack),  64'(reqph && dsel && bif.bus_reqack));
      chk("ibus_respcyc", 64'(bif.ibus_respcyc), 64'(respph && !dsel && bif.bus_respcyc));
      chk("dbus_respcyc", 64'(bif.dbus_respcyc), 64'(respph && dsel && bif.bus_respcyc));
      chk("bus_respack",  64'(bif.bus_respack),  64'(respph && oresp));
      if (reqph) begin
         chk("bus_req",    bif.bus_req,         dsel ? bif.dbus_req : bif.ibus_req);
         chk("bus_reqtag", 64'(bif.bus_reqtag), 64'(dsel ? bif.dbus_reqtag : bif.ibus_reqtag));
      end
      if (respph) begin
         chk("ibus_resp",    bif.ibus_resp,         bif.bus_resp);
         chk("dbus_resp",    bif.dbus_resp,         bif.bus_resp);
         chk("ibus_resptag", 64'(bif.ibus_resptag), 64'(bif.bus_resptag));
         chk("dbus_resptag", 64'(bif.dbus_resptag), 64'(bif.bus_resptag));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bif.ibus_reqcyc = 1'b0; bif.ibus_req = '0; bif.ibus_reqtag = '0; bif.ibus_respack = 1'b0;
      bif.dbus_reqcyc = 1'b0; bif.dbus_req = '0; bif.dbus_reqtag = '0; bif.dbus_respack = 1'b0;
      bif.bus_reqack  = 1'b0; bif.bus_respcyc = 1'b0; bif.bus_resp = '0; bif.bus_resptag = '0;
   endtask

   // Called while the owner sits in the address phase; completes an 8-beat read
   task automatic read_burst(input bit who);
      bif.bus_reqack = 1'b1;
      #1 chk("addr_ack_owner", 64'(who ? bif.dbus_reqack : bif.ibus_reqack), 64'd1);
      tick();
      if (who) bif.dbus_reqcyc = 1'b0; else bif.ibus_reqcyc = 1'b0;
      bif.bus_reqack  = 1'b0;
      bif.bus_respcyc = 1'b1;
      if (who) bif.dbus_respack = 1'b1; else bif.ibus_respack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bif.bus_resp = 64'hA0 + 64'(i);
         #1;
         chk("resp_owner", 64'(who ? bif.dbus_respcyc : bif.ibus_respcyc), 64'd1);
         chk("resp_other", 64'(who ? bif.ibus_respcyc : bif.dbus_respcyc), 64'd0);
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int beats;
      int stall;
      clr();
      reset = 1'b0;
      #3;
      chk("reset_bus_reqcyc",  64'(bif.bus_reqcyc),  64'd0);
      chk("reset_bus_respack", 64'(bif.bus_respack), 64'd0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      tick();

      // ibus read at 0x1000, eight response beats to ibus only
      bif.ibus_reqcyc = 1'b1; bif.ibus_req = 64'h1000; bif.ibus_reqtag = '0;
      #1 chk("grant_latency", 64'(bif.bus_reqcyc), 64'd0);
      tick();
      #1;
      chk("r030_addr",   bif.bus_req, 64'h1000);
      chk("r030_reqcyc", 64'(bif.bus_reqcyc), 64'd1);
      chk("pin_owner_ibus", 64'(m_who), 64'd0);
      read_burst(1'b0);
      #1;
      chk("r030_idle_respcyc", 64'(bif.ibus_respcyc), 64'd0);
      chk("r035_dbus_respcyc", 64'(bif.dbus_respcyc), 64'd0);
      chk("r035_respack",      64'(bif.bus_respack),  64'd0);
      chk("pin_idle_after_8",  64'(m_active), 64'd0);
      clr();
      tick();

      // Contention: DBUS first after reset, then IBUS, then DBUS again
      bif.ibus_reqcyc = 1'b1; bif.ibus_req = 64'h100;
      bif.dbus_reqcyc = 1'b1; bif.dbus_req = 64'h200;
      tick();
      #1 chk("r031_first_dbus", bif.bus_req, 64'h200);
      chk("pin_owner_dbus", 64'(m_who), 64'd1);
      read_burst(1'b1);
      #1 chk("r031_idle_gap", 64'(bif.bus_reqcyc), 64'd0);
      clr();
      bif.ibus_reqcyc = 1'b1; bif.ibus_req = 64'h100;
      tick();
      #1 chk("r031_second_ibus", bif.bus_req, 64'h100);
      read_burst(1'b0);
      clr();
      bif.ibus_reqcyc = 1'b1; bif.ibus_req = 64'h100;
      bif.dbus_reqcyc = 1'b1; bif.dbus_req = 64'h200;
      tick();
      #1 chk("r031_third_dbus", bif.bus_req, 64'h200);

      // Owner withdraws before the address is accepted
      clr();
      tick();
      bif.dbus_reqcyc = 1'b1; bif.dbus_req = 64'h200;
      #1 chk("r021_abort_idle", 64'(bif.bus_reqcyc), 64'd0);
      clr();
      tick();

      // dbus write with a 2-cycle stall at beat 3; stray responses ignored
      bif.dbus_reqcyc = 1'b1; bif.dbus_req = 64'h3000; bif.dbus_reqtag = 13'h1000;
      bif.bus_respcyc = 1'b1; bif.dbus_respack = 1'b1;
      tick();
      bif.bus_reqack = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) begin
         bif.dbus_req = 64'(i);
         if (i == 3) begin
            bif.bus_reqack = 1'b0;
            repeat (2) begin
               #1;
               chk("r032_stall_req", bif.bus_req, 64'd3);
               chk("r032_stall_ack", 64'(bif.dbus_reqack), 64'd0);
               tick();
            end
            bif.bus_reqack = 1'b1;
         end
         #1;
         chk("r032_beat",     bif.bus_req, 64'(i));
         chk("r032_no_resp",  64'(bif.dbus_respcyc), 64'd0);
         tick();
      end
      clr();
      #1 chk("r032_done_idle", 64'(m_active), 64'd0);
      tick();

      // ibus read with respack withheld 2 cycles at beat 5
      bif.ibus_reqcyc = 1'b1; bif.ibus_req = 64'h4000;
      tick();
      bif.bus_reqack = 1'b1;
      tick();
      bif.ibus_reqcyc = 1'b0; bif.bus_reqack = 1'b0; bif.bus_respcyc = 1'b1;
      beats = 0;
      stall = 0;
      for (int k = 0; k < 10; k++) begin
         bif.ibus_respack = !(beats == 4 && stall < 2);
         if (!bif.ibus_respack) stall++;
         #1;
         chk("r033_respack", 64'(bif.bus_respack), 64'(bif.ibus_respack));
         if (bif.ibus_respcyc && bif.bus_respack) beats++;
         tick();
      end
      #1;
      chk("r033_beats", 64'(beats), 64'd8);
      chk("r033_idle",  64'(bif.ibus_respcyc), 64'd0);
      clr();
      tick();

      // Reset in the middle of a read; pending dbus request granted afterwards
      bif.ibus_reqcyc = 1'b1; bif.ibus_req = 64'h5000;
      tick();
      bif.bus_reqack = 1'b1;
      tick();
      bif.ibus_reqcyc = 1'b0; bif.bus_reqack = 1'b0;
      bif.bus_respcyc = 1'b1; bif.ibus_respack = 1'b1; bif.bus_resp = 64'h55;
      repeat (3) tick();
      bif.dbus_reqcyc = 1'b1; bif.dbus_req = 64'h6000; bif.dbus_reqtag = '0;
      #1 reset = 1'b0;
      #1;
      chk("r034_ibus_respcyc", 64'(bif.ibus_respcyc), 64'd0);
      chk("r034_bus_respack",  64'(bif.bus_respack),  64'd0);
      chk("r034_ibus_resp",    bif.ibus_resp,         64'd0);
      chk("r034_bus_reqcyc",   64'(bif.bus_reqcyc),   64'd0);
      #1 reset = 1'b1;
      bif.bus_respcyc = 1'b0; bif.ibus_respack = 1'b0;
      tick();
      #1;
      chk("r034_regrant_req", bif.bus_req, 64'h6000);
      chk("r034_regrant_cyc", 64'(bif.bus_reqcyc), 64'd1);
      clr();
      tick();

      // Random traffic with sticky request lines
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) bif.ibus_reqcyc = !bif.ibus_reqcyc;
         if ($urandom_range(0, 3) == 0) bif.dbus_reqcyc = !bif.dbus_reqcyc;
         bif.ibus_req     = {$urandom, $urandom};
         bif.dbus_req     = {$urandom, $urandom};
         bif.ibus_reqtag  = TW'($urandom);
         bif.dbus_reqtag  = TW'($urandom);
         bif.bus_reqack   = ($urandom_range(0, 9) < 7);
         bif.bus_respcyc  = ($urandom_range(0, 9) < 7);
         bif.bus_resp     = {$urandom, $urandom};
         bif.bus_resptag  = TW'($urandom);
         bif.ibus_respack = ($urandom_range(0, 9) < 8);
         bif.dbus_respack = ($urandom_range(0, 9) < 8);
         if (c == 1500) begin
            #1 reset = 1'b0;
            #2 reset = 1'b1;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
